// File: rtl/pwm_fade_ctrl_if.sv
// Fade command channel: target duty, step size and PWM periods per step,
// transferred on a valid/ready handshake.
interface pwm_fade_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
);
  logic                 valid;
  logic                 ready;
  logic [WIDTH-1:0]     target;
  logic [WIDTH-1:0]     step;
  logic [DIV_WIDTH-1:0] div;

  modport master (output valid, target, step, div, input ready);
  modport slave  (input valid, target, step, div, output ready);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for pwm_generator: ramps duty toward a commanded target,
// moving only on PWM period boundaries so no period is ever truncated.
module pwm_fade_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_fade_ctrl_if.slave   cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             done,
  output logic             period_start
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t               state;
  logic [WIDTH-1:0]     pcnt;
  logic [WIDTH-1:0]     target_reg;
  logic [WIDTH-1:0]     step_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 wrap;
  logic                 accept;
  logic [WIDTH:0]       diff;

  assign wrap         = (pcnt == {WIDTH{1'b1}});
  assign period_start = (pcnt == '0);
  assign cmd.ready    = (state == IDLE) && !abort;
  assign accept       = cmd.valid && cmd.ready;

  // One extra bit so the distance to target can never wrap.
  assign diff = (target_reg >= duty) ? ({1'b0, target_reg} - {1'b0, duty})
                                     : ({1'b0, duty} - {1'b0, target_reg});

  // Free-running period counter; shares reset with pwm_generator to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      target_reg <= '0;
      step_reg   <= WIDTH'(1);
      div_reg    <= DIV_WIDTH'(1);
      div_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target_reg <= cmd.target;
            step_reg   <= (cmd.step == '0) ? WIDTH'(1) : cmd.step;
            div_reg    <= (cmd.div == '0) ? DIV_WIDTH'(1) : cmd.div;
            div_cnt    <= '0;
            if (cmd.target == duty) begin
              done <= 1'b1;
            end else begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
        end
        RAMP: begin
          // Abort takes priority over a step landing on the same edge.
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
          end else if (wrap) begin
            if (div_cnt == div_reg - DIV_WIDTH'(1)) begin
              div_cnt <= '0;
              if (diff <= {1'b0, step_reg}) begin
                duty  <= target_reg;
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (target_reg > duty) begin
                duty <= duty + step_reg;
              end else begin
                duty <= duty - step_reg;
              end
            end else begin
              div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl (WIDTH=8, 256-clock PWM period): ramps,
// clamping, same-target commands, abort priority and asynchronous reset.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] duty;
  logic       busy;
  logic       done;
  logic       period_start;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_pcnt;
  logic [7:0] exp_q[$];

  pwm_fade_ctrl_if #(.WIDTH(8), .DIV_WIDTH(16)) cmd_if ();

  pwm_fade_ctrl #(.WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
    .abort        (abort),
    .duty         (duty),
    .busy         (busy),
    .done         (done),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Expected PWM period position: clocks since reset release, modulo 256.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_pcnt <= 8'd0;
    else        m_pcnt <= m_pcnt + 8'd1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    abort = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.target = 8'd0;
    cmd_if.step = 8'd0;
    cmd_if.div = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one command at a negedge; it is accepted on the following posedge.
  // first_gap = clocks from the negedge after acceptance to the first duty change.
  task automatic send_cmd(input logic [7:0] target, input logic [7:0] step,
                          input logic [15:0] div, output int first_gap);
    int div_eff;
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.target = target;
    cmd_if.step = step;
    cmd_if.div = div;
    #1;
    checks++;
    if (cmd_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: cmd_ready=%b required 1", cmd_if.ready);
    end
    @(negedge clk);
    cmd_if.valid = 1'b0;
    div_eff = (div == 16'd0) ? 1 : int'(div);
    first_gap = (256 - int'(m_pcnt)) + 256 * (div_eff - 1);
    $display("cmd target=%0d step=%0d div=%0d duty_now=%0d first_gap=%0d",
             target, step, div, duty, first_gap);
  endtask

  // Follows duty through every value in exp_q, checking value, timing,
  // period alignment and the done/busy pair at each change.
  task automatic follow_ramp(input string name, input int div, input int first_gap,
                             input bit final_last);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] prev;
      int gap;
      int cnt;
      bit early_done;
      bit is_final;
      prev = duty;
      gap = (i == 0) ? first_gap : 256 * div;
      cnt = 0;
      early_done = 1'b0;
      is_final = final_last && (i == exp_q.size() - 1);
      while (duty === prev && cnt < gap + 10) begin
        @(negedge clk);
        cnt++;
        if (done === 1'b1 && duty === prev) early_done = 1'b1;
      end
      checks++;
      if (duty !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_value[%0d]: duty=%0d required %0d", name, i, duty, exp_q[i]);
      end
      checks++;
      if (cnt != gap) begin
        failures++;
        $display("FAIL %s_gap[%0d]: clocks=%0d required %0d", name, i, cnt, gap);
      end
      checks++;
      if (m_pcnt !== 8'd0) begin
        failures++;
        $display("FAIL %s_align[%0d]: pcnt=%0d required 0", name, i, m_pcnt);
      end
      checks++;
      if (early_done) begin
        failures++;
        $display("FAIL %s_early_done[%0d]: done=1 before step required 0", name, i);
      end
      checks++;
      if (done !== is_final || busy !== !is_final) begin
        failures++;
        $display("FAIL %s_flags[%0d]: done=%b busy=%b required done=%b busy=%b",
                 name, i, done, busy, is_final, !is_final);
      end
      if (is_final) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL %s_done_width: done=%b required 0", name, done);
        end
      end
    end
  endtask

  // Watches for n clocks: duty must stay at hold and done must stay low.
  task automatic hold_check(input string name, input logic [7:0] hold, input int n);
    bit moved;
    bit pulsed;
    moved = 1'b0;
    pulsed = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (duty !== hold) moved = 1'b1;
      if (done !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (moved || pulsed) begin
      failures++;
      $display("FAIL %s_hold: duty=%0d moved=%b flags=%b required %0d/0/0",
               name, duty, moved, pulsed, hold);
    end
  endtask

  task automatic test_reset();
    int highs;
    int bad;
    do_reset();
    #1;
    checks++;
    if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0 ||
        cmd_if.ready !== 1'b1 || period_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: duty=%0d busy=%b done=%b ready=%b pstart=%b required 0/0/0/1/1",
               duty, busy, done, cmd_if.ready, period_start);
    end
    highs = 0;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (period_start === 1'b1) highs++;
      if (period_start !== (m_pcnt == 8'd0)) bad++;
    end
    checks++;
    if (highs != 2 || bad != 0) begin
      failures++;
      $display("FAIL period_start: highs=%0d misaligned=%0d required 2/0", highs, bad);
    end
  endtask

  task automatic test_ramp_up();
    int g;
    send_cmd(8'd100, 8'd10, 16'd1, g);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL ramp_up_busy: busy=%b required 1", busy);
    end
    exp_q = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
    follow_ramp("ramp_up", 1, g, 1'b1);
  endtask

  task automatic test_ramp_down();
    int g;
    send_cmd(8'd3, 8'd25, 16'd2, g);
    exp_q = {8'd75, 8'd50, 8'd25, 8'd3};
    follow_ramp("ramp_down", 2, g, 1'b1);
  endtask

  task automatic test_same_target();
    int g;
    send_cmd(8'd3, 8'd7, 16'd1, g);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || duty !== 8'd3) begin
      failures++;
      $display("FAIL same_target: done=%b busy=%b duty=%0d required 1/0/3", done, busy, duty);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL same_target_width: done=%b required 0", done);
    end
    hold_check("same_target", 8'd3, 300);
  endtask

  task automatic test_abort();
    int g;
    do_reset();
    send_cmd(8'd200, 8'd20, 16'd1, g);
    exp_q = {8'd20};
    follow_ramp("abort_ramp", 1, g, 1'b0);
    // A second command held during RAMP must never be taken.
    cmd_if.valid = 1'b1;
    cmd_if.target = 8'd5;
    cmd_if.step = 8'd1;
    cmd_if.div = 16'd1;
    #1;
    checks++;
    if (cmd_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL ramp_ready: cmd_ready=%b required 0", cmd_if.ready);
    end
    exp_q = {8'd40};
    follow_ramp("abort_ramp2", 1, 256, 1'b0);
    cmd_if.valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || duty !== 8'd40 || cmd_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: busy=%b done=%b duty=%0d ready=%b required 0/0/40/0",
               busy, done, duty, cmd_if.ready);
    end
    abort = 1'b0;
    #1;
    checks++;
    if (cmd_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready: cmd_ready=%b required 1", cmd_if.ready);
    end
    hold_check("abort", 8'd40, 600);
    abort = 1'b1;
    #1;
    checks++;
    if (cmd_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_abort_ready: cmd_ready=%b required 0", cmd_if.ready);
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (cmd_if.ready !== 1'b1 || busy !== 1'b0 || duty !== 8'd40) begin
      failures++;
      $display("FAIL idle_abort_state: ready=%b busy=%b duty=%0d required 1/0/40",
               cmd_if.ready, busy, duty);
    end
  endtask

  task automatic test_abort_final();
    int g;
    int n;
    send_cmd(8'd60, 8'd50, 16'd1, g);
    n = 0;
    while (m_pcnt !== 8'd255 && n < 300) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (duty !== 8'd40 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_final: duty=%0d done=%b busy=%b required 40/0/0", duty, done, busy);
    end
    abort = 1'b0;
    hold_check("abort_final", 8'd40, 300);
  endtask

  task automatic test_clamp_top();
    int g;
    send_cmd(8'd250, 8'd210, 16'd1, g);
    exp_q = {8'd250};
    follow_ramp("exact_step", 1, g, 1'b1);
    send_cmd(8'd255, 8'd0, 16'd0, g);
    exp_q = {8'd251, 8'd252, 8'd253, 8'd254, 8'd255};
    follow_ramp("clamp_top", 1, g, 1'b1);
    hold_check("clamp_top", 8'd255, 300);
  endtask

  task automatic test_reset_mid_ramp();
    int g;
    send_cmd(8'd200, 8'd5, 16'd1, g);
    exp_q = {8'd250};
    follow_ramp("pre_reset", 1, g, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: duty=%0d busy=%b done=%b pstart=%b required 0/0/0/1",
               duty, busy, done, period_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold_check("after_reset", 8'd0, 300);
  endtask

  initial begin
    cmd_if.valid = 1'b0;
    cmd_if.target = 8'd0;
    cmd_if.step = 8'd0;
    cmd_if.div = 16'd0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_same_target();
    test_abort();
    test_abort_final();
    test_clamp_top();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
